// File: rtl/online_digit_pkg.sv
// Shared digit codes and sequencer state encodings for the online-digit read path.
package online_digit_pkg;

  localparam logic [1:0] DIGIT_ZERO    = 2'b00;
  localparam logic [1:0] DIGIT_POS     = 2'b01;
  localparam logic [1:0] DIGIT_NEG     = 2'b10;
  localparam logic [1:0] DIGIT_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_t;

endpackage

// File: rtl/online_digit_reader_if.sv
// Valid/ready digit stream from the reader to the online divider datapath.
interface online_digit_reader_if #(
  parameter int DATA_WIDTH = 2
);
  logic [DATA_WIDTH-1:0] digit_out;
  logic                  digit_valid;
  logic                  digit_ready;
  logic                  digit_last;
  logic                  digit_err;

  modport master (
    output digit_out, digit_valid, digit_last, digit_err,
    input  digit_ready
  );

  modport slave (
    input  digit_out, digit_valid, digit_last, digit_err,
    output digit_ready
  );
endinterface

// File: rtl/online_digit_fifo.sv
// Small synchronous FIFO holding {last, digit} entries between the RAM read pipe and the consumer.
module online_digit_fifo #(
  parameter  int WIDTH = 3,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign do_pop   = pop & ~empty;
  // a push into a full buffer is legal when the head leaves on the same edge
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];
  assign count    = count_q;

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/online_digit_reader.sv
// Read-side sequencer: streams LEN signed digits from the online-digit RAM into a valid/ready stream.
//   state    | meaning
//   ST_IDLE  | waiting for start; done pulse shown here for one cycle after a transfer
//   ST_READ  | issuing one RAM read per cycle while credit allows
//   ST_DRAIN | all reads issued; waiting for pipe and buffer to empty
module online_digit_reader
  import online_digit_pkg::*;
#(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 7,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  clear_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] ram_q,
  online_digit_reader_if.master dig
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]         OCC_LIMIT = (CW+1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] REM_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [CW-1:0]       CNT_ONE   = CW'(1);

  rd_state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [ADDR_WIDTH:0]   remaining_q;
  logic [ADDR_WIDTH-1:0] read_addr_q;
  logic [1:0]            inflight_v;
  logic [1:0]            inflight_last;
  logic                  done_q;
  logic                  err_q;

  logic                  accept;
  logic                  issue;
  logic                  credit_ok;
  logic                  drain_done;
  logic [CW:0]           occupied;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic [DATA_WIDTH:0]   fifo_push_data;
  logic [DATA_WIDTH:0]   fifo_pop_data;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;

  // credit counts reads still in the RAM pipe so a push always finds room
  assign occupied   = {1'b0, fifo_count}
                    + {{CW{1'b0}}, inflight_v[0]}
                    + {{CW{1'b0}}, inflight_v[1]};
  assign credit_ok  = (occupied < OCC_LIMIT);
  assign accept     = (state_q == ST_IDLE) && start && !done_q;
  assign issue      = (state_q == ST_READ) && (remaining_q != '0) && credit_ok;
  assign drain_done = (state_q == ST_DRAIN) && !inflight_v[0] && !inflight_v[1]
                    && (fifo_empty || ((fifo_count == CNT_ONE) && fifo_pop));

  always_ff @(posedge clk) begin
    if (!clear_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = (len == '0) ? ST_DRAIN : ST_READ;
      ST_READ:  if (issue && (remaining_q == REM_ONE)) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    busy = (state_q != ST_IDLE) || done_q;
    done = done_q;
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      ptr_q         <= '0;
      remaining_q   <= '0;
      read_addr_q   <= '0;
      inflight_v    <= '0;
      inflight_last <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      done_q        <= drain_done;
      inflight_v    <= {inflight_v[0], issue};
      inflight_last <= {inflight_last[0], issue && (remaining_q == REM_ONE)};
      if (accept) begin
        ptr_q       <= base_addr;
        remaining_q <= len;
        err_q       <= 1'b0;
      end
      if (issue) begin
        read_addr_q <= ptr_q;
        ptr_q       <= ptr_q + 1'b1;
        remaining_q <= remaining_q - 1'b1;
      end
      if (inflight_v[1] && (ram_q == DIGIT_ILLEGAL)) err_q <= 1'b1;
    end
  end

  assign read_addr      = read_addr_q;
  assign fifo_push      = inflight_v[1];
  assign fifo_push_data = {inflight_last[1], ram_q};
  assign fifo_pop       = dig.digit_valid && dig.digit_ready;

  online_digit_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .clear_n   (clear_n),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_pop_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // stale buffer contents are masked so the stream reads as zero when idle
  assign dig.digit_valid = !fifo_empty;
  assign dig.digit_out   = fifo_empty ? '0 : fifo_pop_data[DATA_WIDTH-1:0];
  assign dig.digit_last  = !fifo_empty && fifo_pop_data[DATA_WIDTH];
  assign dig.digit_err   = err_q;

endmodule

// File: tb/tb_online_digit_reader.sv
// Scoreboard bench for online_digit_reader with a registered-address RAM model.
module tb_online_digit_reader;
  import online_digit_pkg::*;

  localparam int AW = 7;
  localparam int DW = 2;
  localparam int FD = 4;
  localparam int RAM_SIZE = 1 << AW;

  typedef struct {
    logic [DW-1:0] digit;
    logic          last;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          clear_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   len = '0;
  logic          busy;
  logic          done;
  logic [AW-1:0] read_addr;
  logic [DW-1:0] ram_q;

  online_digit_reader_if #(.DATA_WIDTH(DW)) dig();

  online_digit_reader #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk       (clk),
    .clear_n   (clear_n),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .read_addr (read_addr),
    .ram_q     (ram_q),
    .dig       (dig)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [RAM_SIZE];
  logic [AW-1:0] ram_addr_q = '0;
  always @(posedge clk) ram_addr_q <= read_addr;
  assign ram_q = mem[ram_addr_q];

  exp_t sb[$];
  int   addr_log[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   pop_cnt, valid_cnt, busy_cnt, done_cnt;
  int   first_valid_cyc, last_cyc, done_cyc, max_occ;
  logic [AW-1:0] prev_addr;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] stall_digit;
  logic          stall_last;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (clear_n) begin
      exp_t e;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (dig.digit_valid) begin
        valid_cnt++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (int'(dut.u_fifo.count) > max_occ) max_occ = int'(dut.u_fifo.count);
      if (busy && read_addr != prev_addr) begin
        addr_log.push_back(int'(read_addr));
        prev_addr = read_addr;
      end
      if (stall_prev) begin
        chk("stall_valid", dig.digit_valid, 1);
        chk("stall_digit", dig.digit_out, stall_digit);
        chk("stall_last", dig.digit_last, stall_last);
      end
      stall_prev  = dig.digit_valid && !dig.digit_ready;
      stall_digit = dig.digit_out;
      stall_last  = dig.digit_last;
      if (dig.digit_valid && dig.digit_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_digit", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("digit", dig.digit_out, e.digit);
          chk("last", dig.digit_last, e.last);
          chk("err", dig.digit_err, e.err);
          pop_cnt++;
          if (e.last) last_cyc = cyc;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_counters();
    pop_cnt = 0; valid_cnt = 0; busy_cnt = 0; done_cnt = 0;
    first_valid_cyc = -1; last_cyc = -1; done_cyc = -1; max_occ = 0;
    addr_log.delete();
    prev_addr = read_addr;
  endtask

  task automatic launch(input int b, input int l, output int se);
    logic acc;
    logic [DW-1:0] d;
    acc = 1'b0;
    for (int i = 0; i < l; i++) begin
      d = mem[(b + i) % RAM_SIZE];
      acc = acc | (d == DIGIT_ILLEGAL);
      sb.push_back('{digit: d, last: (i == l - 1), err: acc});
    end
    base_addr = AW'(b);
    len = (AW+1)'(l);
    start = 1'b1;
    se = cyc + 1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, input bit toggle);
    int snap;
    int n;
    snap = done_cnt;
    n = 0;
    while (done_cnt == snap && n < max_cycles) begin
      tick();
      if (toggle) dig.digit_ready = ~dig.digit_ready;
      n++;
    end
    chk("done_seen", done_cnt - snap, 1);
    dig.digit_ready = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    int se;
    int exp_a[4];
    int n;
    dig.digit_ready = 1'b1;
    for (int i = 0; i < RAM_SIZE; i++) mem[i] = DW'($urandom_range(0, 2));
    mem[10] = DIGIT_POS; mem[11] = DIGIT_NEG; mem[12] = DIGIT_ZERO; mem[13] = DIGIT_POS;
    mem[4] = DIGIT_POS; mem[5] = DIGIT_ILLEGAL; mem[6] = DIGIT_NEG;

    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", dig.digit_valid, 0);
    chk("rst_last", dig.digit_last, 0);
    chk("rst_err", dig.digit_err, 0);
    chk("rst_read_addr", read_addr, 0);
    clear_n = 1'b1;
    tick();

    // 1: basic stream and latency
    reset_counters();
    launch(10, 4, se);
    wait_done(40, 0);
    chk("t1_first_lat", first_valid_cyc - se, 3);
    chk("t1_last_spacing", last_cyc - first_valid_cyc, 3);
    chk("t1_done_lat", done_cyc - last_cyc, 1);
    chk("t1_valid_cycles", valid_cnt, 4);
    chk("t1_done_pulses", done_cnt, 1);
    chk("t1_sb_left", sb.size(), 0);

    // 2: address wrap
    reset_counters();
    exp_a = '{126, 127, 0, 1};
    launch(126, 4, se);
    wait_done(40, 0);
    chk("t2_addr_count", addr_log.size(), 4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++) chk("t2_addr", addr_log[i], exp_a[i]);
    chk("t2_pops", pop_cnt, 4);
    chk("t2_sb_left", sb.size(), 0);

    // 3: consumer stalls every other cycle
    reset_counters();
    launch(60, 6, se);
    wait_done(80, 1);
    chk("t3_pops", pop_cnt, 6);
    chk("t3_occ_bound", max_occ <= FD, 1);
    chk("t3_sb_left", sb.size(), 0);

    // 4: zero length
    reset_counters();
    launch(30, 0, se);
    wait_done(20, 0);
    tick();
    chk("t4_valid_cycles", valid_cnt, 0);
    chk("t4_busy_cycles", busy_cnt, 2);
    chk("t4_done_pulses", done_cnt, 1);

    // 5: illegal code, sticky error, start while busy ignored
    reset_counters();
    launch(4, 3, se);
    base_addr = 7'd100;
    len = 8'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(40, 0);
    tick();
    chk("t5_pops", pop_cnt, 3);
    chk("t5_err_sticky", dig.digit_err, 1);
    chk("t5_idle_after", busy, 0);
    chk("t5_done_pulses", done_cnt, 1);
    chk("t5_sb_left", sb.size(), 0);

    // 6: abort by reset mid-transfer, then a fresh transfer
    reset_counters();
    launch(20, 8, se);
    chk("t6_err_cleared", dig.digit_err, 0);
    n = 0;
    while (pop_cnt < 2 && n < 50) begin
      tick();
      n++;
    end
    chk("t6_two_popped", pop_cnt, 2);
    clear_n = 1'b0;
    tick();
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_valid", dig.digit_valid, 0);
    chk("t6_last", dig.digit_last, 0);
    chk("t6_err", dig.digit_err, 0);
    chk("t6_read_addr", read_addr, 0);
    clear_n = 1'b1;
    sb.delete();
    reset_counters();
    repeat (10) tick();
    chk("t6_no_done", done_cnt, 0);
    chk("t6_no_valid", valid_cnt, 0);
    reset_counters();
    exp_a = '{40, 41, 42, 0};
    launch(40, 3, se);
    wait_done(40, 0);
    chk("t6_first_lat", first_valid_cyc - se, 3);
    chk("t6_pops", pop_cnt, 3);
    chk("t6_addr_count", addr_log.size(), 3);
    for (int i = 0; i < 3 && i < addr_log.size(); i++) chk("t6_addr", addr_log[i], exp_a[i]);
    chk("t6_sb_left", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
